// File: rtl/dmem_banked.sv
// rtl/dmem_banked.sv - byte-addressable big-endian data memory with configurable access latency
//
// Parameters:
//   ADDR_W  byte-address bits used (depth = 2**ADDR_W bytes)
//   LAT     extra wait cycles per access (0..7)
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned stores write nothing, misaligned loads return 0
//   undefined -> misaligned accesses are performed bytewise with wrap-around
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   MemRead, MemWrite    load / store request (store wins when both are high)
//   addr, data           byte address (low ADDR_W bits used), right-aligned store data
//   size, ld_unsigned    00 byte, 01 half, 1x word; zero- vs sign-extend loads
//   stall                high while the present request has not yet completed
//   DM_data, rd_valid    registered load result, one-cycle pulse after load completion
//   misalign             alignment status of the last completed access
module dmem_banked #(
  parameter int ADDR_W = 7,
  parameter int LAT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic        stall,
  output logic [31:0] DM_data,
  output logic        rd_valid,
  output logic        misalign
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        req, done;
  logic        is_half, is_word, mis, trap, we, load_done;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0] raw, ld_val;
  logic [7:0]  mem [0:(2**ADDR_W)-1];
  logic        unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  assign req   = MemRead | MemWrite;
  assign done  = req && (cnt == 3'(LAT));
  assign stall = req && (cnt != 3'(LAT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A dropped request or a completion both return to IDLE with cnt = 0.
  always_comb begin
    state_nx = IDLE;
    cnt_nx   = 3'd0;
    case (state)
      IDLE: if (req && !done) begin
        state_nx = BUSY;
        cnt_nx   = 3'd1;
      end
      BUSY: if (req && !done) begin
        state_nx = BUSY;
        cnt_nx   = cnt + 3'd1;
      end
      default: ;
    endcase
  end

  // Byte lane addresses wrap modulo the memory depth.
  assign a0 = addr[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  assign is_half = (size == 2'b01);
  assign is_word = size[1];
  assign mis     = (is_half && a0[0]) || (is_word && (a0[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = mis;
`else
  assign trap = 1'b0;
`endif

  assign we        = done && MemWrite && !trap;
  assign load_done = done && MemRead && !MemWrite;

  // Memory is not reset; rst only blocks a write on an edge where it is held high.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      if (is_word) begin
        mem[a0] <= data[31:24];
        mem[a1] <= data[23:16];
        mem[a2] <= data[15:8];
        mem[a3] <= data[7:0];
      end else if (is_half) begin
        mem[a0] <= data[15:8];
        mem[a1] <= data[7:0];
      end else begin
        mem[a0] <= data[7:0];
      end
    end
  end

  always_comb begin
    raw = 32'd0;
    if (is_word)      raw = {mem[a0], mem[a1], mem[a2], mem[a3]};
    else if (is_half) raw = {16'd0, mem[a0], mem[a1]};
    else              raw = {24'd0, mem[a0]};
  end

  always_comb begin
    ld_val = raw;
    if (is_half)       ld_val = {{16{!ld_unsigned && raw[15]}}, raw[15:0]};
    else if (!is_word) ld_val = {{24{!ld_unsigned && raw[7]}}, raw[7:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DM_data  <= 32'd0;
      rd_valid <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rd_valid <= load_done;
      if (done)      misalign <= mis;
      if (load_done) DM_data  <= trap ? 32'd0 : ld_val;
    end
  end

endmodule
